// File: rtl/branch_resolve_unit.sv
// Branch resolution: outcome evaluation, 2-bit BHT, mispredict pulse, statistics.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             res_pred,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [31:0]      instr,
  output logic             pc_src,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count,
  input  logic             stat_clr
);

  localparam int unsigned DEPTH = 2 ** BHT_IDX;

  logic [BHT_IDX-1:0] pred_idx;
  logic [BHT_IDX-1:0] res_idx;
  logic [2:0]         funct3;
  logic               legal_f3;
  logic               taken;
  logic               legal_cf;
  logic               miss_cond;
  logic               bht_upd;

  logic [1:0]         bht_q [DEPTH];
  logic [1:0]         bht_d [DEPTH];
  logic               mispredict_q;
  logic               mispredict_d;
  logic [CNT_W-1:0]   br_count_q;
  logic [CNT_W-1:0]   br_count_d;
  logic [CNT_W-1:0]   miss_count_q;
  logic [CNT_W-1:0]   miss_count_d;

  logic               unused_bits;

  always_comb begin
    pred_idx    = pred_pc[BHT_IDX+1:2];
    res_idx     = res_pc[BHT_IDX+1:2];
    funct3      = instr[14:12];
    unused_bits = ^{instr[31:15], instr[11:0],
                    pred_pc[XLEN-1:BHT_IDX+2], pred_pc[1:0],
                    res_pc[XLEN-1:BHT_IDX+2], res_pc[1:0]};
  end

  always_comb begin
    legal_f3 = (funct3[2:1] != 2'b01);
    taken    = 1'b0;
    if (jump) begin
      taken = 1'b1;
    end else if (branch) begin
      case (funct3)
        3'b000:  taken = zero;
        3'b001:  taken = !zero;
        3'b100:  taken = lt;
        3'b101:  taken = !lt;
        3'b110:  taken = ltu;
        3'b111:  taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
    pc_src    = res_valid && taken;
    legal_cf  = res_valid && (jump || (branch && legal_f3));
    miss_cond = legal_cf && (res_pred != taken);
    bht_upd   = res_valid && branch && !jump && legal_f3;
  end

  always_comb begin
    bht_d = bht_q;
    if (bht_upd) begin
      if (taken && (bht_q[res_idx] != 2'b11)) begin
        bht_d[res_idx] = bht_q[res_idx] + 2'b01;
      end else if (!taken && (bht_q[res_idx] != 2'b00)) begin
        bht_d[res_idx] = bht_q[res_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    mispredict_d = miss_cond;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (stat_clr) begin
      br_count_d   = '0;
      miss_count_d = '0;
    end else begin
      if (legal_cf && (br_count_q != '1)) begin
        br_count_d = br_count_q + 1'b1;
      end
      if (miss_cond && (miss_count_q != '1)) begin
        miss_count_d = miss_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
      mispredict_q <= 1'b0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      bht_q        <= bht_d;
      mispredict_q <= mispredict_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    pred_taken = bht_q[pred_idx][1];
    mispredict = mispredict_q;
    br_count   = br_count_q;
    miss_count = miss_count_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_pred;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic [31:0] instr;
  logic        stat_clr;

  logic        pred_taken;
  logic        pc_src;
  logic        mispredict;
  logic [15:0] br_count;
  logic [15:0] miss_count;

  logic        pred_taken4;
  logic        pc_src4;
  logic        mispredict4;
  logic [3:0]  br_count4;
  logic [3:0]  miss_count4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .res_valid  (res_valid),
    .res_pc     (res_pc),
    .res_pred   (res_pred),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .instr      (instr),
    .pc_src     (pc_src),
    .mispredict (mispredict),
    .br_count   (br_count),
    .miss_count (miss_count),
    .stat_clr   (stat_clr)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken4),
    .res_valid  (res_valid),
    .res_pc     (res_pc),
    .res_pred   (res_pred),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .instr      (instr),
    .pc_src     (pc_src4),
    .mispredict (mispredict4),
    .br_count   (br_count4),
    .miss_count (miss_count4),
    .stat_clr   (stat_clr)
  );

  task automatic idle();
    res_valid = 1'b0; res_pc = '0; res_pred = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    instr = '0; stat_clr = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic jp,
                         input logic [2:0] f3, input logic z, input logic l,
                         input logic pr);
    res_valid = 1'b1; res_pc = pc; branch = br; jump = jp;
    instr = {17'b0, f3, 12'b0}; zero = z; lt = l; ltu = 1'b0; res_pred = pr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    pred_pc = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 16; i++) begin
      pred_pc = i * 4;
      #1;
      n_cmp++;
      if (pred_taken !== 1'b0) begin
        n_fail++; $display("FAIL reset_pred[%0d]: got %b want 0", i, pred_taken);
      end
    end
    n_cmp++;
    if ({mispredict, br_count, miss_count} !== 33'd0) begin
      n_fail++; $display("FAIL reset_regs: got misp=%b br=%0d miss=%0d want 0/0/0",
                         mispredict, br_count, miss_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_update();
    resolve(32'h10, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (pc_src !== 1'b1) begin
      n_fail++; $display("FAIL t1_pc_src: got %b want 1", pc_src);
    end
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL t1_misp_early: got %b want 0", mispredict);
    end
    step();
    idle();
    pred_pc = 32'h10;
    #1;
    n_cmp++;
    if (mispredict !== 1'b1) begin
      n_fail++; $display("FAIL t1_misp: got %b want 1", mispredict);
    end
    n_cmp++;
    if (br_count !== 16'd1 || miss_count !== 16'd1) begin
      n_fail++; $display("FAIL t1_counts: got br=%0d miss=%0d want 1/1", br_count, miss_count);
    end
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL t1_pred: got %b want 1", pred_taken);
    end
    step();
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL t1_misp_pulse_end: got %b want 0", mispredict);
    end
  endtask

  task automatic test_saturate();
    logic exp_nt [3];
    exp_nt[0] = 1'b1; exp_nt[1] = 1'b0; exp_nt[2] = 1'b0;
    pred_pc = 32'h20;
    for (int i = 0; i < 6; i++) begin
      resolve(32'h20, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0);
      step();
    end
    idle();
    #1;
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL t2_sat_pred: got %b want 1", pred_taken);
    end
    for (int i = 0; i < 3; i++) begin
      resolve(32'h20, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (pred_taken !== exp_nt[i]) begin
        n_fail++; $display("FAIL t2_nt_pred[%0d]: got %b want %b", i, pred_taken, exp_nt[i]);
      end
    end
    idle();
    n_cmp++;
    if (br_count !== 16'd10 || miss_count !== 16'd7) begin
      n_fail++; $display("FAIL t2_counts: got br=%0d miss=%0d want 10/7", br_count, miss_count);
    end
  endtask

  task automatic test_jump();
    resolve(32'h10, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (pc_src !== 1'b1) begin
      n_fail++; $display("FAIL t3_pc_src: got %b want 1", pc_src);
    end
    step();
    idle();
    pred_pc = 32'h10;
    #1;
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL t3_misp: got %b want 0", mispredict);
    end
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL t3_table: got %b want 1", pred_taken);
    end
    n_cmp++;
    if (br_count !== 16'd11 || miss_count !== 16'd7) begin
      n_fail++; $display("FAIL t3_counts: got br=%0d miss=%0d want 11/7", br_count, miss_count);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      resolve(32'h10, 1'b1, 1'b0, (i == 0) ? 3'b010 : 3'b011, 1'b1, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if (pc_src !== 1'b0) begin
        n_fail++; $display("FAIL t4_pc_src[%0d]: got %b want 0", i, pc_src);
      end
      step();
      n_cmp++;
      if (mispredict !== 1'b0) begin
        n_fail++; $display("FAIL t4_misp[%0d]: got %b want 0", i, mispredict);
      end
    end
    idle();
    pred_pc = 32'h10;
    #1;
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL t4_table: got %b want 1", pred_taken);
    end
    n_cmp++;
    if (br_count !== 16'd11 || miss_count !== 16'd7) begin
      n_fail++; $display("FAIL t4_counts: got br=%0d miss=%0d want 11/7", br_count, miss_count);
    end
  endtask

  task automatic test_valid_low();
    resolve(32'h34, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    res_valid = 1'b0;
    #1;
    n_cmp++;
    if (pc_src !== 1'b0) begin
      n_fail++; $display("FAIL t5_pc_src: got %b want 0", pc_src);
    end
    step();
    idle();
    pred_pc = 32'h34;
    #1;
    n_cmp++;
    if (pred_taken !== 1'b0 || mispredict !== 1'b0) begin
      n_fail++; $display("FAIL t5_state: got pred=%b misp=%b want 0/0", pred_taken, mispredict);
    end
    n_cmp++;
    if (br_count !== 16'd11 || miss_count !== 16'd7) begin
      n_fail++; $display("FAIL t5_counts: got br=%0d miss=%0d want 11/7", br_count, miss_count);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_m [3];
    exp_m[0] = 1'b1; exp_m[1] = 1'b1; exp_m[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resolve(32'h3C, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0);
      step();
      n_cmp++;
      if (mispredict !== exp_m[i]) begin
        n_fail++; $display("FAIL t6_misp[%0d]: got %b want %b", i, mispredict, exp_m[i]);
      end
    end
    idle();
    n_cmp++;
    if (br_count !== 16'd14 || miss_count !== 16'd9) begin
      n_fail++; $display("FAIL t6_counts: got br=%0d miss=%0d want 14/9", br_count, miss_count);
    end
  endtask

  task automatic test_stat_clr();
    resolve(32'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    stat_clr = 1'b1;
    step();
    idle();
    n_cmp++;
    if (br_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL t7_clr: got br=%0d miss=%0d want 0/0", br_count, miss_count);
    end
    n_cmp++;
    if (mispredict !== 1'b1) begin
      n_fail++; $display("FAIL t7_misp: got %b want 1", mispredict);
    end
    n_cmp++;
    if (br_count4 !== 4'd0 || miss_count4 !== 4'd0) begin
      n_fail++; $display("FAIL t7_clr4: got br=%0d miss=%0d want 0/0", br_count4, miss_count4);
    end
  endtask

  task automatic test_sat4();
    for (int i = 0; i < 20; i++) begin
      resolve(32'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      step();
      if (i == 13) begin
        n_cmp++;
        if (br_count4 !== 4'd14 || miss_count4 !== 4'd14) begin
          n_fail++; $display("FAIL t8_cnt14: got br=%0d miss=%0d want 14/14", br_count4, miss_count4);
        end
      end
    end
    n_cmp++;
    if (br_count4 !== 4'd15 || miss_count4 !== 4'd15) begin
      n_fail++; $display("FAIL t8_sat: got br=%0d miss=%0d want 15/15", br_count4, miss_count4);
    end
    n_cmp++;
    if (br_count !== 16'd20 || miss_count !== 16'd20) begin
      n_fail++; $display("FAIL t8_wide: got br=%0d miss=%0d want 20/20", br_count, miss_count);
    end
    stat_clr = 1'b1;
    step();
    idle();
    n_cmp++;
    if (br_count4 !== 4'd0 || miss_count4 !== 4'd0) begin
      n_fail++; $display("FAIL t8_clr: got br=%0d miss=%0d want 0/0", br_count4, miss_count4);
    end
  endtask

  task automatic test_same_cycle_and_async_reset();
    pred_pc = 32'h30;
    resolve(32'h30, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL t9_pred_pre: got %b want 0", pred_taken);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL t9_pred_post: got %b want 1", pred_taken);
    end
    resolve(32'h00, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (mispredict !== 1'b1) begin
      n_fail++; $display("FAIL t9_misp_before_rst: got %b want 1", mispredict);
    end
    #1;
    rst_n = 1'b0;
    res_valid = 1'b0;
    #1;
    n_cmp++;
    if ({pred_taken, pc_src, mispredict, br_count, miss_count} !== 35'd0) begin
      n_fail++; $display("FAIL t9_async_rst: got pred=%b pc_src=%b misp=%b br=%0d miss=%0d want all 0",
                         pred_taken, pc_src, mispredict, br_count, miss_count);
    end
    step();
    n_cmp++;
    if (mispredict !== 1'b0 || mispredict4 !== 1'b0) begin
      n_fail++; $display("FAIL t9_pending_drop: got %b/%b want 0/0", mispredict, mispredict4);
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_first_update();
    test_saturate();
    test_jump();
    test_illegal();
    test_valid_low();
    test_back_to_back();
    test_stat_clr();
    test_sat4();
    test_same_cycle_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
